reg_nibble_reader: RTL and testbench
====================================

REG_NIBBLE_READER -- requirements
Module: reg_nibble_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of data bits read out per transaction; legal range is 1..16.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1; 1 means bit 0 is sent first, 0 means bit WIDTH-1 is sent first.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is an asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 Port start  input  1  requests capture of data_in and serial readout.
REQ-006 Port data_in  input  WIDTH  is the parallel register contents to be read.
REQ-007 Port ser_ready  input  1  signals that the consumer accepts the current serial bit.
REQ-008 Port ser_out  output  1  carries the serial data bit.
REQ-009 Port ser_valid  output  1  signals that ser_out holds a bit to be transferred.
REQ-010 Port busy  output  1  is high from capture until the end of the DONE state.
REQ-011 Port done  output  1  is a one-cycle pulse marking transaction completion.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL capture data_in into an internal shift register, clear the bit counter and enter SHIFT on that same edge.
REQ-014 In IDLE, busy, ser_valid and done SHALL be 0, and ser_out SHALL be 0.
REQ-015 In SHIFT, ser_valid SHALL be 1 and ser_out SHALL present the current head bit of the shift register (bit 0 when LSB_FIRST=1, bit WIDTH-1 otherwise).
REQ-016 A bit SHALL be transferred only on a rising edge where ser_valid=1 and ser_ready=1; the shift register then advances by one and the counter increments.
REQ-017 While ser_valid=1 and ser_ready=0, ser_out and all internal state SHALL hold stable, with no timeout.
REQ-018 On transfer of the final bit (count reaches WIDTH, or WIDTH+1 with parity), the FSM SHALL enter DONE; ser_valid SHALL drop in the same cycle that DONE is entered.
REQ-019 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE unconditionally.
REQ-020 start SHALL be ignored in SHIFT and DONE; a start held high through DONE SHALL begin a new capture on the first IDLE edge, one cycle after DONE.
REQ-021 Changes on data_in after capture SHALL NOT affect the transaction in progress.
REQ-022 Minimum transaction latency (ser_ready held 1) SHALL be WIDTH cycles in SHIFT plus 1 cycle in DONE, i.e. WIDTH+1 cycles from the capture edge to the return to IDLE (one more with parity).
REQ-023 The counter SHALL be sized to hold WIDTH+1 without wrap-around.

Reset
REQ-024 Asserting reset=0 SHALL immediately force state IDLE, with shift register=0, counter=0, ser_out=0, ser_valid=0, busy=0 and done=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the transaction with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-026 On release of reset, the block SHALL act on start no earlier than the first rising edge at which reset=1.

Configuration
REQ-027 When macro READER_PARITY_EN is defined, the block SHALL send one extra bit after the data bits, equal to the even parity (XOR) of the captured word, with the same handshake.
REQ-028 When READER_PARITY_EN is undefined, no parity bit SHALL be sent and no parity logic SHALL be present.

Verification
REQ-029 Scenario: reset release; start=1 with data_in=4'b1011; ser_ready=1 -> ser_out 1,1,0,1 on consecutive cycles, then done pulse; busy high for 5 cycles.
REQ-030 Scenario: data_in=4'b0110 with ser_ready toggling 1,0,0,1,1,0,1 -> ser_out holds each bit while ready=0; bit sequence 0,1,1,0; exactly one done pulse.
REQ-031 Scenario: start re-pulsed during SHIFT while data_in is changed to 4'b1111 -> the transmitted word is still the captured value; no second transaction starts.
REQ-032 Scenario: reset=0 after the 2nd bit of data_in=4'b1001 -> all outputs 0 immediately; no done pulse; a fresh start after release sends 1,0,0,1.
REQ-033 Scenario: LSB_FIRST=0, data_in=4'b1000 -> ser_out sequence 1,0,0,0.
REQ-034 Scenario: READER_PARITY_EN defined, data_in=4'b0111 -> five bits 1,1,1,0,1, then done.

Source files
------------

// File: rtl/reg_nibble_reader.sv
// Parallel-load, serial-readout register reader with a valid/ready bit handshake.
// Optional even-parity trailer bit is enabled by defining READER_PARITY_EN.
module reg_nibble_reader #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef READER_PARITY_EN
    localparam int NUM_BITS = WIDTH + 1;
`else
    localparam int NUM_BITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_shiftReg;
    logic [WIDTH-1:0]   w_shifted;
    logic [CNT_W-1:0]   r_count;
    logic               w_load;
    logic               w_advance;
    logic               w_headBit;
    logic               w_txBit;

    assign w_headBit = (LSB_FIRST != 0) ? r_shiftReg[0] : r_shiftReg[WIDTH-1];
    assign w_shifted = (LSB_FIRST != 0) ? (r_shiftReg >> 1) : (r_shiftReg << 1);

`ifdef READER_PARITY_EN
    logic r_parity;

    // Once all data bits are out, the counter sits at WIDTH and the trailer goes out.
    assign w_txBit = (r_count == CNT_W'(WIDTH)) ? r_parity : w_headBit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^data_in;
        end
    end
`else
    assign w_txBit = w_headBit;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_out   = w_txBit;
                if (ser_ready) begin
                    w_advance = 1'b1;
                    if (r_count == LAST_IDX) begin
                        w_nextState = DONE;
                    end
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The word is frozen at capture, so later data_in activity cannot disturb a readout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shiftReg <= '0;
            r_count    <= '0;
        end else if (w_load) begin
            r_shiftReg <= data_in;
            r_count    <= '0;
        end else if (w_advance) begin
            r_shiftReg <= w_shifted;
            r_count    <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_nibble_reader.sv
// Table-driven bench for reg_nibble_reader, plus hand-written readout, reset-abort and MSB-first sequences.
// Expectations follow READER_PARITY_EN when it is defined for the build.
module tb_reg_nibble_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] data_in;
    logic       ser_ready;
    logic       ser_out, ser_valid, busy, done;

    logic       msbStart;
    logic [3:0] msbData;
    logic       msbReady;
    logic       msbOut, msbValid, msbBusy, msbDone;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic       rstN;
        logic       st;
        logic [3:0] d;
        logic       rdy;
        logic       eOut;
        logic       eValid;
        logic       eBusy;
        logic       eDone;
        string      name;
    } vec_t;

    vec_t vecs[$];

    reg_nibble_reader #(.WIDTH(4), .LSB_FIRST(1)) u_lsb (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .ser_ready(ser_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .busy     (busy),
        .done     (done)
    );

    reg_nibble_reader #(.WIDTH(4), .LSB_FIRST(0)) u_msb (
        .clk      (clk),
        .reset    (reset),
        .start    (msbStart),
        .data_in  (msbData),
        .ser_ready(msbReady),
        .ser_out  (msbOut),
        .ser_valid(msbValid),
        .busy     (msbBusy),
        .done     (msbDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act != exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rstN, input logic st, input logic [3:0] d, input logic rdy,
                          input logic eOut, input logic eValid, input logic eBusy, input logic eDone,
                          input string name);
        vec_t v;
        v.rstN = rstN; v.st = st; v.d = d; v.rdy = rdy;
        v.eOut = eOut; v.eValid = eValid; v.eBusy = eBusy; v.eDone = eDone;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rstN;
        start     = v.st;
        data_in   = v.d;
        ser_ready = v.rdy;
        @(posedge clk);
        #1;
    endtask

    // Starts a transaction on one instance with ready held high and collects the bits it sends.
    task automatic runWord(input logic useMsb, input logic [3:0] d, input logic [4:0] expBits,
                           input int nBits, input string name);
        int         got   = 0;
        int         dones = 0;
        logic [4:0] bits  = '0;
        logic       v, o, dn;
        if (useMsb) begin
            msbStart = 1'b1; msbData = d; msbReady = 1'b1;
        end else begin
            start = 1'b1; data_in = d; ser_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        msbStart = 1'b0;
        start    = 1'b0;
        for (int c = 0; c < 20 && dones == 0; c++) begin
            v  = useMsb ? msbValid : ser_valid;
            o  = useMsb ? msbOut   : ser_out;
            dn = useMsb ? msbDone  : done;
            if (v) begin
                if (got < 5) bits[got] = o;
                got++;
            end
            if (dn) dones++;
            if (dones == 0) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput({name, ".doneSeen"}, dones, 1);
        checkOutput({name, ".bitCount"}, got, nBits);
        for (int b = 0; b < nBits; b++) begin
            checkOutput($sformatf("%s.bit%0d", name, b), int'(bits[b]), int'(expBits[b]));
        end
        @(posedge clk);
        #1;
        checkOutput({name, ".idleBusy"}, int'(useMsb ? msbBusy : busy), 0);
        msbReady = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; data_in = 4'h0; ser_ready = 1'b0;
        msbStart = 1'b0; msbData = 4'h0; msbReady = 1'b0;
        #2;
        checkOutput("reset.out",   int'(ser_out),   0);
        checkOutput("reset.valid", int'(ser_valid), 0);
        checkOutput("reset.busy",  int'(busy),      0);
        checkOutput("reset.done",  int'(done),      0);
        repeat (2) @(posedge clk);
        #1;

        // Plain readout of 1011, released from reset on the capture edge.
        addVec(1, 1, 4'b1011, 1, 1, 1, 1, 0, "s1");
        addVec(1, 0, 4'b1011, 1, 1, 1, 1, 0, "s1");
        addVec(1, 0, 4'b1011, 1, 0, 1, 1, 0, "s1");
        addVec(1, 0, 4'b1011, 1, 1, 1, 1, 0, "s1");
`ifdef READER_PARITY_EN
        addVec(1, 0, 4'b1011, 1, 1, 1, 1, 0, "s1");
`endif
        addVec(1, 0, 4'b1011, 1, 0, 0, 1, 1, "s1");
        addVec(1, 0, 4'b1011, 1, 0, 0, 0, 0, "s1");

        // 0110 with ready stalls: each bit holds while ready is low.
        addVec(1, 1, 4'b0110, 0, 0, 1, 1, 0, "s2");
        addVec(1, 0, 4'b0110, 1, 1, 1, 1, 0, "s2");
        addVec(1, 0, 4'b0110, 0, 1, 1, 1, 0, "s2");
        addVec(1, 0, 4'b0110, 0, 1, 1, 1, 0, "s2");
        addVec(1, 0, 4'b0110, 1, 1, 1, 1, 0, "s2");
        addVec(1, 0, 4'b0110, 1, 0, 1, 1, 0, "s2");
        addVec(1, 0, 4'b0110, 0, 0, 1, 1, 0, "s2");
`ifdef READER_PARITY_EN
        addVec(1, 0, 4'b0110, 1, 0, 1, 1, 0, "s2");
`endif
        addVec(1, 0, 4'b0110, 1, 0, 0, 1, 1, "s2");
        addVec(1, 0, 4'b0110, 1, 0, 0, 0, 0, "s2");

        // Capture 0010, then re-pulse start with data_in forced to 1111.
        addVec(1, 1, 4'b0010, 1, 0, 1, 1, 0, "s3");
        addVec(1, 1, 4'b1111, 1, 1, 1, 1, 0, "s3");
        addVec(1, 0, 4'b1111, 1, 0, 1, 1, 0, "s3");
        addVec(1, 1, 4'b1111, 1, 0, 1, 1, 0, "s3");
`ifdef READER_PARITY_EN
        addVec(1, 0, 4'b1111, 1, 1, 1, 1, 0, "s3");
`endif
        addVec(1, 0, 4'b1111, 1, 0, 0, 1, 1, "s3");
        addVec(1, 0, 4'b1111, 1, 0, 0, 0, 0, "s3");

        // start held high throughout: ignored in DONE, recaptured on the following IDLE edge.
        addVec(1, 1, 4'b0001, 1, 1, 1, 1, 0, "s4");
        addVec(1, 1, 4'b0001, 1, 0, 1, 1, 0, "s4");
        addVec(1, 1, 4'b0001, 1, 0, 1, 1, 0, "s4");
        addVec(1, 1, 4'b0001, 1, 0, 1, 1, 0, "s4");
`ifdef READER_PARITY_EN
        addVec(1, 1, 4'b0001, 1, 1, 1, 1, 0, "s4");
`endif
        addVec(1, 1, 4'b0001, 1, 0, 0, 1, 1, "s4");
        addVec(1, 1, 4'b0001, 1, 0, 0, 0, 0, "s4");
        addVec(1, 1, 4'b0001, 1, 1, 1, 1, 0, "s4");
        addVec(0, 1, 4'b1111, 1, 0, 0, 0, 0, "s4");
        addVec(1, 0, 4'b1111, 1, 0, 0, 0, 0, "s4");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            if (!vecs[i].eDone)
                checkOutput($sformatf("%s[%0d].out", vecs[i].name, i), int'(ser_out), int'(vecs[i].eOut));
            checkOutput($sformatf("%s[%0d].valid", vecs[i].name, i), int'(ser_valid), int'(vecs[i].eValid));
            checkOutput($sformatf("%s[%0d].busy", vecs[i].name, i), int'(busy), int'(vecs[i].eBusy));
            checkOutput($sformatf("%s[%0d].done", vecs[i].name, i), int'(done), int'(vecs[i].eDone));
        end

`ifdef READER_PARITY_EN
        runWord(1'b0, 4'b0111, 5'b10111, 5, "lsb0111");
        runWord(1'b1, 4'b1000, 5'b10001, 5, "msb1000");
`else
        runWord(1'b0, 4'b0111, 5'b00111, 4, "lsb0111");
        runWord(1'b1, 4'b1000, 5'b00001, 4, "msb1000");
`endif

        // Abort 1001 after two bits have been transferred.
        start = 1'b1; data_in = 4'b1001; ser_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("abort.bit0", int'(ser_out), 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort.midValid", int'(ser_valid), 1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("abort.out",   int'(ser_out),   0);
        checkOutput("abort.valid", int'(ser_valid), 0);
        checkOutput("abort.busy",  int'(busy),      0);
        checkOutput("abort.done",  int'(done),      0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("abort.held%0d.done", c), int'(done), 0);
            checkOutput($sformatf("abort.held%0d.busy", c), int'(busy), 0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort.waitIdle", int'(busy), 0);
`ifdef READER_PARITY_EN
        runWord(1'b0, 4'b1001, 5'b01001, 5, "restart1001");
`else
        runWord(1'b0, 4'b1001, 5'b01001, 4, "restart1001");
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
